rtob_cmd_assembler: RTL
=======================

// Module: rtob_cmd_assembler
// PURPOSE
//  Upstream feeder for the TTLx8 RTOB core. Collects 32-bit host writes into one 128-bit
//  {timestamp[63:0], data[63:0]} entry and issues a single-cycle write into the RTOB FIFO.
//  Holds the entry while the core reports full, so the core never sees a write-while-full overflow.
//  Rejects non-monotonic timestamps and generates the core flush pulse.
// PARAMETERS
//  DATA_LEN     8     valid data bits; entry data bits [63:DATA_LEN] forced to 0
//  STALL_LIMIT  4096  max cycles an entry waits on full before it is dropped (>=1)
//  CNT_LEN      13    stall counter width; must hold STALL_LIMIT
// PORTS
//  clk           in   1    system clock
//  reset         in   1    synchronous active-high reset
//  s_wr_valid    in   1    host word write strobe
//  s_wr_addr     in   2    word index: 0=data[31:0] 1=data[63:32] 2=ts[31:0] 3=ts[63:32]+commit
//  s_wr_data     in   32   host word
//  s_wr_ready    out  1    word accepted when s_wr_valid && s_wr_ready
//  flush_req     in   1    request core flush (level, sampled each cycle)
//  core_full     in   1    RTOB full (programmable-full) flag
//  fifo_din      out  128  entry to core {ts, data}
//  write         out  1    one-cycle core write strobe
//  flush         out  1    one-cycle core flush strobe
//  order_error   out  1    one-cycle pulse: entry rejected, ts < last committed ts
//  drop_error    out  1    one-cycle pulse: entry dropped after STALL_LIMIT full cycles
//  busy          out  1    state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0 except s_wr_ready=0 during reset, 1 the first cycle after; shadow regs,
//   last_ts, have_last, stall_cnt cleared; state=IDLE. Reset mid-stall discards the held entry.
//  FSM IDLE/ISSUE/STALL/FLUSH.
//  IDLE: s_wr_ready=1. Accepted words at addr 0..2 load the shadow regs only. Addr 3 loads ts[63:32]
//   and:
//   - ts < last_ts && have_last -> order_error next cycle, stay IDLE, no write.
//   - else core_full=0 -> ISSUE.
//   - else -> STALL.
//  Equal timestamps are legal; the core merges them.
//  ISSUE (1 cycle): write=1, fifo_din valid the same cycle; last_ts<=ts, have_last<=1; ->IDLE.
//   Latency: commit word accepted at cycle N -> write high at N+1.
//  STALL: s_wr_ready=0; stall_cnt++ each cycle.
//   - core_full=0 -> ISSUE, cnt cleared.
//   - cnt==STALL_LIMIT-1 and still full -> drop_error pulse, ->IDLE, last_ts unchanged.
//  fifo_din is registered and held stable from commit until write; it changes only on an ISSUE load.
//  flush_req has priority over everything in any state:
//   - ->FLUSH, flush=1 for exactly one cycle;
//   - pending entry discarded, no write; shadow regs, last_ts and have_last cleared;
//   - s_wr_ready=0 in FLUSH, ->IDLE next cycle.
//  A flush_req held high re-pulses flush every 2 cycles.
//  Simultaneous flush_req and commit word: the commit word is not accepted (s_wr_ready sampled
//   low by design, flush wins).
//  write and flush are never high in the same cycle.
//  64-bit ts compare is unsigned; ts wrap-around is not supported (treated as order error).
// STRUCTURE
//  Package rtob_pkg: typedef rtob_entry_t {logic[63:0] ts; logic[63:0] data;}, enum asm_state_t,
//   localparams for word indices.
//  One flat module. No sub-module; the stall counter stays inline.
// TESTING
//  1. Words 0..3 = 0xAB,0,0x100,0; core_full=0
//     -> write 1 cycle after word 3, fifo_din=0x0000000000000100_00000000000000AB.
//  2. DATA_LEN=8, data word 0x1234 -> fifo_din[63:0]=0xAB-style mask -> 0x34.
//  3. Commit ts=0x200, then commit ts=0x1FF
//     -> order_error pulse, no second write; ts=0x200 again -> write.
//  4. core_full=1 at commit, released after 10 cycles -> s_wr_ready=0 for 10 cycles, one write,
//     no overflow.
//  5. core_full held, STALL_LIMIT=16 -> drop_error at 16th stall cycle, no write, IDLE after.
//  6. flush_req during STALL -> flush pulse, no write, next ts=0 commit accepted (have_last cleared).

Source files
------------

// File: rtl/rtob_pkg.sv
// Shared types for the RTOB command assembler: entry layout, FSM states, host word indices.
package rtob_pkg;

  typedef struct packed {
    logic [63:0] ts;
    logic [63:0] data;
  } rtob_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } asm_state_t;

  localparam logic [1:0] W_DATA_LO = 2'd0;
  localparam logic [1:0] W_DATA_HI = 2'd1;
  localparam logic [1:0] W_TS_LO   = 2'd2;
  localparam logic [1:0] W_TS_HI   = 2'd3;

  function automatic logic [63:0] data_mask(input int unsigned len);
    if (len >= 64) return '1;
    return (64'd1 << len) - 64'd1;
  endfunction

endpackage

// File: rtl/rtob_cmd_assembler.sv
// Builds 128-bit {ts, data} RTOB entries from 32-bit host writes and issues them to the core,
// holding across core_full, rejecting out-of-order timestamps and generating the flush pulse.
module rtob_cmd_assembler
  import rtob_pkg::*;
#(
  parameter int DATA_LEN    = 8,
  parameter int STALL_LIMIT = 4096,
  parameter int CNT_LEN     = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_wr_valid,
  input  logic [1:0]   s_wr_addr,
  input  logic [31:0]  s_wr_data,
  output logic         s_wr_ready,
  input  logic         flush_req,
  input  logic         core_full,
  output logic [127:0] fifo_din,
  output logic         write,
  output logic         flush,
  output logic         order_error,
  output logic         drop_error,
  output logic         busy
);

  localparam logic [63:0] MASK = data_mask(DATA_LEN);
  localparam logic [CNT_LEN-1:0] CNT_LAST = CNT_LEN'(STALL_LIMIT - 1);

  asm_state_t         state;
  rtob_entry_t        entry_q;
  logic [63:0]        sh_data;
  logic [31:0]        sh_ts_lo;
  logic [31:0]        sh_ts_hi;
  logic [63:0]        last_ts;
  logic               have_last;
  logic [CNT_LEN-1:0] stall_cnt;
  logic               acc;
  logic [63:0]        commit_ts;

  // Flush wins over a same-cycle host word by dropping ready.
  assign s_wr_ready = !reset && !flush_req && (state == IDLE);
  assign acc        = s_wr_valid && s_wr_ready;
  assign commit_ts  = {s_wr_data, sh_ts_lo};
  assign fifo_din   = entry_q;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      entry_q     <= '0;
      sh_data     <= '0;
      sh_ts_lo    <= '0;
      sh_ts_hi    <= '0;
      last_ts     <= '0;
      have_last   <= 1'b0;
      stall_cnt   <= '0;
      write       <= 1'b0;
      flush       <= 1'b0;
      order_error <= 1'b0;
      drop_error  <= 1'b0;
    end else begin
      write       <= 1'b0;
      flush       <= 1'b0;
      order_error <= 1'b0;
      drop_error  <= 1'b0;
      // FLUSH always returns to IDLE, so a held request re-pulses every other cycle.
      if (flush_req && state != FLUSH) begin
        state     <= FLUSH;
        flush     <= 1'b1;
        sh_data   <= '0;
        sh_ts_lo  <= '0;
        sh_ts_hi  <= '0;
        last_ts   <= '0;
        have_last <= 1'b0;
        stall_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (acc) begin
              case (s_wr_addr)
                W_DATA_LO: sh_data[31:0]  <= s_wr_data;
                W_DATA_HI: sh_data[63:32] <= s_wr_data;
                W_TS_LO:   sh_ts_lo       <= s_wr_data;
                W_TS_HI: begin
                  sh_ts_hi <= s_wr_data;
                  if (have_last && commit_ts < last_ts) begin
                    order_error <= 1'b1;
                  end else if (!core_full) begin
                    state   <= ISSUE;
                    write   <= 1'b1;
                    entry_q <= '{ts: commit_ts, data: sh_data & MASK};
                  end else begin
                    state     <= STALL;
                    stall_cnt <= '0;
                  end
                end
              endcase
            end
          end
          ISSUE: begin
            last_ts   <= entry_q.ts;
            have_last <= 1'b1;
            state     <= IDLE;
          end
          STALL: begin
            if (!core_full) begin
              state     <= ISSUE;
              write     <= 1'b1;
              entry_q   <= '{ts: {sh_ts_hi, sh_ts_lo}, data: sh_data & MASK};
              stall_cnt <= '0;
            end else if (stall_cnt == CNT_LAST) begin
              state      <= IDLE;
              drop_error <= 1'b1;
              stall_cnt  <= '0;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
          FLUSH: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
